// File: rtl/rst_seq_gen.sv
// rst_seq_gen: tick-rate prescaler, debounced reset button and staggered,
// strictly ordered release of NUM_RST active-low reset domains.
module rst_seq_gen #(
    parameter int DIV        = 500,
    parameter int FILT_LEN   = 8,
    parameter int HOLD_TICKS = 4,
    parameter int NUM_RST    = 3,
    parameter int STAGGER    = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               rst_btn_n,
    output logic               tick,
    output logic [NUM_RST-1:0] sysrstn,
    output logic               ready
);

    localparam int CW = $clog2(DIV);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);
    localparam logic [SW-1:0] STAG_ONE  = SW'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic [1:0]          sync_r;
    logic                btn_s;
    logic [CW-1:0]       cnt_r;
    logic                tick_r;
    logic [FILT_LEN-1:0] flt_r;
    logic [FILT_LEN-1:0] flt_next_s;
    logic                btn_ok_s;
    state_t              state_r;
    logic [HW-1:0]       hold_cnt_r;
    logic [SW-1:0]       stag_cnt_r;
    logic [NUM_RST-1:0]  sysrstn_r;
    logic [NUM_RST-1:0]  rel_next_s;
    logic                ready_r;

    assign btn_s      = sync_r[1];
    assign flt_next_s = FILT_LEN'({flt_r, btn_s});
    assign btn_ok_s   = &flt_r;
    // Released domains form a thermometer code, so shifting in a 1 frees the next index.
    assign rel_next_s = NUM_RST'({sysrstn_r, 1'b1});

    assign tick    = tick_r;
    assign sysrstn = sysrstn_r;
    assign ready   = ready_r;

    // Two-stage synchroniser for the raw button.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], rst_btn_n};
        end
    end

    // Prescaler: free-running 0..DIV-1 counter, tick registered one cycle after the wrap value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            tick_r <= (cnt_r == CNT_LAST);
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Button filter: one sample per tick; release needs FILT_LEN consecutive highs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flt_r <= {FILT_LEN{1'b0}};
        end else if (tick_r) begin
            flt_r <= flt_next_s;
        end else begin
            flt_r <= flt_r;
        end
    end

    // Sequencer: hold all domains, then release them one per STAGGER ticks; abort wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_ASSERT;
            hold_cnt_r <= {HW{1'b0}};
            stag_cnt_r <= {SW{1'b0}};
            sysrstn_r  <= {NUM_RST{1'b0}};
            ready_r    <= 1'b0;
        end else if ((state_r != ST_ASSERT) && !btn_ok_s) begin
            state_r    <= ST_ASSERT;
            hold_cnt_r <= {HW{1'b0}};
            stag_cnt_r <= {SW{1'b0}};
            sysrstn_r  <= {NUM_RST{1'b0}};
            ready_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    if (btn_ok_s) begin
                        state_r    <= ST_HOLD;
                        hold_cnt_r <= {HW{1'b0}};
                    end else begin
                        state_r <= ST_ASSERT;
                    end
                end
                ST_HOLD: begin
                    if (tick_r) begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            sysrstn_r  <= rel_next_s;
                            ready_r    <= &rel_next_s;
                            stag_cnt_r <= {SW{1'b0}};
                            state_r    <= (&rel_next_s) ? ST_RUN : ST_RELEASE;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_RELEASE: begin
                    if (tick_r) begin
                        if (stag_cnt_r == STAG_LAST) begin
                            sysrstn_r  <= rel_next_s;
                            ready_r    <= &rel_next_s;
                            stag_cnt_r <= {SW{1'b0}};
                            state_r    <= (&rel_next_s) ? ST_RUN : ST_RELEASE;
                        end else begin
                            stag_cnt_r <= stag_cnt_r + STAG_ONE;
                        end
                    end else begin
                        state_r <= ST_RELEASE;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r    <= ST_ASSERT;
                    hold_cnt_r <= {HW{1'b0}};
                    stag_cnt_r <= {SW{1'b0}};
                    sysrstn_r  <= {NUM_RST{1'b0}};
                    ready_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: four parameter sets share clk/rstn/button and are
// compared every cycle against a count-based reference model plus fixed vectors.
module tb_rst_seq_gen;

    typedef struct packed {
        int div;
        int filt;
        int hold;
        int nrst;
        int stag;
    } mparam_t;

    typedef struct packed {
        int   cyc;
        logic s1;
        logic s2;
        int   run;
        logic mode;
        int   k;
    } mstate_t;

    localparam mparam_t PA = '{div: 4, filt: 3, hold: 2, nrst: 3, stag: 2};
    localparam mparam_t PB = '{div: 4, filt: 3, hold: 2, nrst: 1, stag: 2};
    localparam mparam_t PC = '{div: 4, filt: 3, hold: 2, nrst: 4, stag: 1};
    localparam mparam_t PD = '{div: 2, filt: 3, hold: 2, nrst: 3, stag: 2};

    logic       clk = 1'b0;
    logic       rstn;
    logic       rst_btn_n;
    logic       tick_a, tick_b, tick_c, tick_d;
    logic [2:0] sys_a;
    logic [0:0] sys_b;
    logic [3:0] sys_c;
    logic [2:0] sys_d;
    logic       rdy_a, rdy_b, rdy_c, rdy_d;

    int checks = 0;
    int failures = 0;
    int ecnt = 0;

    mstate_t ma, mb, mc, md;

    always #5 clk = ~clk;

    rst_seq_gen #(.DIV(4), .FILT_LEN(3), .HOLD_TICKS(2), .NUM_RST(3), .STAGGER(2)) u_a (
        .clk(clk), .rstn(rstn), .rst_btn_n(rst_btn_n), .tick(tick_a), .sysrstn(sys_a), .ready(rdy_a));
    rst_seq_gen #(.DIV(4), .FILT_LEN(3), .HOLD_TICKS(2), .NUM_RST(1), .STAGGER(2)) u_b (
        .clk(clk), .rstn(rstn), .rst_btn_n(rst_btn_n), .tick(tick_b), .sysrstn(sys_b), .ready(rdy_b));
    rst_seq_gen #(.DIV(4), .FILT_LEN(3), .HOLD_TICKS(2), .NUM_RST(4), .STAGGER(1)) u_c (
        .clk(clk), .rstn(rstn), .rst_btn_n(rst_btn_n), .tick(tick_c), .sysrstn(sys_c), .ready(rdy_c));
    rst_seq_gen #(.DIV(2), .FILT_LEN(3), .HOLD_TICKS(2), .NUM_RST(3), .STAGGER(2)) u_d (
        .clk(clk), .rstn(rstn), .rst_btn_n(rst_btn_n), .tick(tick_d), .sysrstn(sys_d), .ready(rdy_d));

    // Reference model: tick from edge count, filter as a run length, release from ticks elapsed.
    function automatic logic m_tick(input mstate_t m, input mparam_t p);
        return (m.cyc > 0) && ((m.cyc % p.div) == 0);
    endfunction

    function automatic int m_sys(input mstate_t m, input mparam_t p);
        int r;
        if (!m.mode || m.k < p.hold) r = 0;
        else r = 1 + (m.k - p.hold) / p.stag;
        if (r > p.nrst) r = p.nrst;
        return (1 << r) - 1;
    endfunction

    function automatic mstate_t m_step(input mstate_t m, input mparam_t p, input logic btn);
        mstate_t n;
        logic tk;
        logic ok;
        n  = m;
        tk = m_tick(m, p);
        ok = (m.run >= p.filt);
        n.cyc = m.cyc + 1;
        n.s1  = btn;
        n.s2  = m.s1;
        if (tk) n.run = m.s2 ? ((m.run < p.filt) ? m.run + 1 : m.run) : 0;
        if (m.mode && !ok) begin
            n.mode = 1'b0;
            n.k    = 0;
        end else if (!m.mode && ok) begin
            n.mode = 1'b1;
            n.k    = 0;
        end else if (m.mode && tk) begin
            n.k = m.k + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ma <= '0; mb <= '0; mc <= '0; md <= '0;
        end else begin
            ma <= m_step(ma, PA, rst_btn_n);
            mb <= m_step(mb, PB, rst_btn_n);
            mc <= m_step(mc, PC, rst_btn_n);
            md <= m_step(md, PD, rst_btn_n);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string nm, input logic t, input int s, input logic r,
                             input mstate_t m, input mparam_t p);
        int es;
        es = m_sys(m, p);
        chk({nm, ".tick"}, int'(t), int'(m_tick(m, p)));
        chk({nm, ".sysrstn"}, s, es);
        chk({nm, ".ready"}, int'(r), (es == (1 << p.nrst) - 1) ? 1 : 0);
    endtask

    // One clock: wait for the falling edge, then compare every instance with its model.
    task automatic cyc();
        @(negedge clk);
        ecnt++;
        cmp_model("a", tick_a, int'(sys_a), rdy_a, ma, PA);
        cmp_model("b", tick_b, int'(sys_b), rdy_b, mb, PB);
        cmp_model("c", tick_c, int'(sys_c), rdy_c, mc, PC);
        cmp_model("d", tick_d, int'(sys_d), rdy_d, md, PD);
    endtask

    task automatic run_to(input int n);
        while (ecnt < n) cyc();
    endtask

    typedef struct {
        int n;
        int tick_a;
        int sys_a;
        int sys_b;
        int sys_c;
        int tick_d;
        int sys_d;
    } vec_t;

    vec_t vt[15];

    task automatic powerup_table();
        for (int i = 0; i < 15; i++) begin
            run_to(vt[i].n);
            chk($sformatf("vec%0d.tick_a", vt[i].n), int'(tick_a), vt[i].tick_a);
            chk($sformatf("vec%0d.sys_a", vt[i].n), int'(sys_a), vt[i].sys_a);
            chk($sformatf("vec%0d.rdy_a", vt[i].n), int'(rdy_a), (vt[i].sys_a == 7) ? 1 : 0);
            chk($sformatf("vec%0d.sys_b", vt[i].n), int'(sys_b), vt[i].sys_b);
            chk($sformatf("vec%0d.rdy_b", vt[i].n), int'(rdy_b), vt[i].sys_b);
            chk($sformatf("vec%0d.sys_c", vt[i].n), int'(sys_c), vt[i].sys_c);
            chk($sformatf("vec%0d.rdy_c", vt[i].n), int'(rdy_c), (vt[i].sys_c == 15) ? 1 : 0);
            chk($sformatf("vec%0d.tick_d", vt[i].n), int'(tick_d), vt[i].tick_d);
            chk($sformatf("vec%0d.sys_d", vt[i].n), int'(sys_d), vt[i].sys_d);
            chk($sformatf("vec%0d.rdy_d", vt[i].n), int'(rdy_d), (vt[i].sys_d == 7) ? 1 : 0);
        end
    endtask

    task automatic release_rstn();
        rstn = 1'b1;
        ecnt = 0;
    endtask

    initial begin
        // {edges after rstn release, tick_a, sys_a, sys_b, sys_c, tick_d, sys_d}
        vt[0]  = '{1,  0, 0, 0, 0,  0, 0};
        vt[1]  = '{3,  0, 0, 0, 0,  0, 0};
        vt[2]  = '{4,  1, 0, 0, 0,  1, 0};
        vt[3]  = '{5,  0, 0, 0, 0,  0, 0};
        vt[4]  = '{8,  1, 0, 0, 0,  1, 0};
        vt[5]  = '{11, 0, 0, 0, 0,  0, 1};
        vt[6]  = '{15, 0, 0, 0, 0,  0, 3};
        vt[7]  = '{19, 0, 0, 0, 0,  0, 7};
        vt[8]  = '{20, 1, 0, 0, 0,  1, 7};
        vt[9]  = '{21, 0, 1, 1, 1,  0, 7};
        vt[10] = '{25, 0, 1, 1, 3,  0, 7};
        vt[11] = '{29, 0, 3, 1, 7,  0, 7};
        vt[12] = '{33, 0, 3, 1, 15, 0, 7};
        vt[13] = '{37, 0, 7, 1, 15, 0, 7};
        vt[14] = '{40, 1, 7, 1, 15, 1, 7};

        rstn      = 1'b0;
        rst_btn_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.tick", int'(tick_a), 0);
        chk("reset.sysrstn", int'(sys_a), 0);
        chk("reset.ready", int'(rdy_a), 0);

        // Power-up with the button held released.
        release_rstn();
        powerup_table();

        // Press in RUN spanning the tick sample at edge 45.
        rst_btn_n = 1'b0;
        run_to(44);
        rst_btn_n = 1'b1;
        run_to(45);
        chk("press.before", int'(sys_a), 7);
        run_to(46);
        chk("press.abort_sys", int'(sys_a), 0);
        chk("press.abort_rdy", int'(rdy_a), 0);
        run_to(64);
        chk("refill.still_held", int'(sys_a), 0);
        run_to(65);
        chk("refill.bit0", int'(sys_a), 1);
        run_to(73);
        chk("refill.bit1", int'(sys_a), 3);
        run_to(81);
        chk("refill.all", int'(sys_a), 7);
        chk("refill.ready", int'(rdy_a), 1);

        // Two-clock low between tick samples of instance a: ignored.
        run_to(83);
        rst_btn_n = 1'b0;
        run_to(85);
        rst_btn_n = 1'b1;
        run_to(92);
        chk("glitch_between.sys", int'(sys_a), 7);
        chk("glitch_between.rdy", int'(rdy_a), 1);

        // Same two-clock low straddling the sample at edge 97: full abort.
        run_to(94);
        rst_btn_n = 1'b0;
        run_to(96);
        rst_btn_n = 1'b1;
        run_to(97);
        chk("glitch_on_tick.before", int'(sys_a), 7);
        run_to(98);
        chk("glitch_on_tick.abort", int'(sys_a), 0);

        // Async reset while only bit 0 is released, between clock edges.
        run_to(120);
        chk("mid_release.tick", int'(tick_a), 1);
        chk("mid_release.sys", int'(sys_a), 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("async.tick", int'(tick_a), 0);
        chk("async.sys", int'(sys_a), 0);
        chk("async.rdy", int'(rdy_a), 0);
        chk("async.sys_c", int'(sys_c), 0);
        repeat (3) cyc();
        release_rstn();
        powerup_table();

        // Randomised button activity with occasional power-on resets.
        for (int r = 0; r < 60; r++) begin
            rst_btn_n = 1'b1;
            repeat ($urandom_range(10, 120)) cyc();
            rst_btn_n = 1'b0;
            repeat ($urandom_range(1, 10)) cyc();
            if ($urandom_range(0, 9) == 0) begin
                rstn = 1'b0;
                repeat ($urandom_range(1, 3)) cyc();
                rstn = 1'b1;
            end
        end
        rst_btn_n = 1'b1;
        repeat (60) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
